// File: rtl/norm_shift_pipe.sv
// norm_shift_pipe: two-stage mantissa normalization (left shift + exponent adjust) with valid/ready flow.
// Build option: define NORM_DENORM_EN to produce denormals on underflow; otherwise underflow flushes to zero.
module norm_shift_pipe #(
  parameter int SIZE_DATA = 24,
  parameter int SIZE_LOPD = 5,
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_CNT  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_sign,
  input  logic [SIZE_EXP-1:0]  i_exp,
  input  logic [SIZE_DATA-1:0] i_mant,
  input  logic [SIZE_LOPD-1:0] i_one_position,
  input  logic                 i_zero_flag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_sign,
  output logic [SIZE_EXP-1:0]  o_exp,
  output logic [SIZE_DATA-1:0] o_mant,
  output logic                 o_zero,
  output logic                 o_underflow,
  output logic [SIZE_CNT-1:0]  o_underflow_cnt
);

  typedef enum logic [1:0] {
    PATH_ZERO   = 2'd0,
    PATH_NORMAL = 2'd1,
    PATH_UNDER  = 2'd2
  } path_e;

  localparam int                 EXP_W1  = SIZE_EXP + 1;
  localparam logic [SIZE_LOPD-1:0] MAX_POS = SIZE_LOPD'(SIZE_DATA - 1);

  logic w_s2_adv;
  logic w_s1_adv;
  logic w_in_xfer;
  logic w_out_xfer;

  logic                 r_s1_valid;
  logic                 r_s1_sign;
  logic [SIZE_DATA-1:0] r_s1_mant;
  path_e                r_s1_path;
  logic [SIZE_LOPD-1:0] r_s1_shamt;
  logic [SIZE_EXP-1:0]  r_s1_exp;

  assign w_s2_adv   = ~o_valid | i_ready;
  assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
  assign o_ready    = w_s1_adv;
  assign w_in_xfer  = i_valid & w_s1_adv;
  assign w_out_xfer = o_valid & i_ready;

  // Stage 1 decode: path, shift amount and result exponent.
  logic [SIZE_LOPD-1:0] w_pos;
  logic [SIZE_LOPD-1:0] w_sh;
  logic [SIZE_LOPD-1:0] w_shamt;
  logic [SIZE_EXP-1:0]  w_exp_adj;
  path_e                w_path;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no branch can infer a latch.
    w_pos     = (i_one_position > MAX_POS) ? MAX_POS : i_one_position;
    w_sh      = MAX_POS - w_pos;
    w_path    = PATH_UNDER;
    w_shamt   = '0;
    w_exp_adj = '0;
    if (i_zero_flag) begin
      w_path = PATH_ZERO;
    end else if ({1'b0, i_exp} > EXP_W1'(w_sh)) begin
      w_path    = PATH_NORMAL;
      w_shamt   = w_sh;
      w_exp_adj = i_exp - SIZE_EXP'(w_sh);
    end
`ifdef NORM_DENORM_EN
    // Denormal: shift only until the exponent would reach 1; i_exp-1 < sh, so it fits.
    else if (i_exp != '0) begin
      w_shamt = SIZE_LOPD'(i_exp - SIZE_EXP'(1));
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mant  <= '0;
      r_s1_path  <= PATH_ZERO;
      r_s1_shamt <= '0;
      r_s1_exp   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= i_valid;
      if (w_in_xfer) begin
        r_s1_sign  <= i_sign;
        r_s1_mant  <= i_mant;
        r_s1_path  <= w_path;
        r_s1_shamt <= w_shamt;
        r_s1_exp   <= w_exp_adj;
      end
    end
  end

  // Stage 2 datapath: apply the shift and form the result fields.
  logic [SIZE_DATA-1:0] w_shifted;
  logic [SIZE_DATA-1:0] w_mant_nx;
  logic [SIZE_EXP-1:0]  w_exp_nx;
  logic                 w_zero_nx;
  logic                 w_under_nx;

  always_comb begin
    w_shifted  = r_s1_mant << r_s1_shamt;
    w_mant_nx  = '0;
    w_exp_nx   = '0;
    w_zero_nx  = 1'b0;
    w_under_nx = 1'b0;
    case (r_s1_path)
      PATH_NORMAL: begin
        w_mant_nx = w_shifted;
        w_exp_nx  = r_s1_exp;
      end
      PATH_UNDER: begin
        w_under_nx = 1'b1;
`ifdef NORM_DENORM_EN
        w_mant_nx  = w_shifted;
        w_zero_nx  = (w_shifted == '0);
`else
        w_zero_nx  = 1'b1;
`endif
      end
      default: begin
        w_zero_nx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid     <= 1'b0;
      o_sign      <= 1'b0;
      o_exp       <= '0;
      o_mant      <= '0;
      o_zero      <= 1'b0;
      o_underflow <= 1'b0;
    end else if (w_s2_adv) begin
      o_valid <= r_s1_valid;
      if (r_s1_valid) begin
        o_sign      <= r_s1_sign;
        o_exp       <= w_exp_nx;
        o_mant      <= w_mant_nx;
        o_zero      <= w_zero_nx;
        o_underflow <= w_under_nx;
      end
    end
  end

  // Counts underflow results actually handed downstream; sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_underflow_cnt <= '0;
    end else if (w_out_xfer && o_underflow && !(&o_underflow_cnt)) begin
      o_underflow_cnt <= o_underflow_cnt + SIZE_CNT'(1);
    end
  end

endmodule

// File: tb/tb_norm_shift_pipe.sv
// tb_norm_shift_pipe: directed vectors checked against an arithmetic model and scoreboard every cycle.
// Build with NORM_DENORM_EN defined to check the denormal variant.
module tb_norm_shift_pipe;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [7:0]  i_exp;
  logic [23:0] i_mant;
  logic [4:0]  i_one_position;
  logic        i_zero_flag;
  logic        o_valid;
  logic        i_ready;
  logic        o_sign;
  logic [7:0]  o_exp;
  logic [23:0] o_mant;
  logic        o_zero;
  logic        o_underflow;
  logic [15:0] o_underflow_cnt;

  norm_shift_pipe dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_sign          (i_sign),
    .i_exp           (i_exp),
    .i_mant          (i_mant),
    .i_one_position  (i_one_position),
    .i_zero_flag     (i_zero_flag),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_sign          (o_sign),
    .o_exp           (o_exp),
    .o_mant          (o_mant),
    .o_zero          (o_zero),
    .o_underflow     (o_underflow),
    .o_underflow_cnt (o_underflow_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        zero;
    logic        under;
    int          t;
  } beat_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    cnt_model = 0;
  int    n_out    = 0;
  bit    saw_ready_low = 1'b0;
  beat_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result straight from the normalization rules, using wide integer arithmetic.
  function automatic beat_t model(input bit s, input int e, input int m, input int p, input bit zf);
    beat_t  r;
    int     pos;
    int     sh;
    longint wide;
    pos    = (p > 23) ? 23 : p;
    sh     = 23 - pos;
    r.sign = s;
    r.t    = 0;
    r.exp  = 8'd0;
    r.mant = 24'd0;
    r.zero = 1'b0;
    r.under = 1'b0;
    if (zf) begin
      r.zero = 1'b1;
    end else if (e > sh) begin
      wide   = longint'(m) << sh;
      r.mant = 24'(wide & 64'hFF_FFFF);
      r.exp  = 8'(e - sh);
    end else begin
      r.under = 1'b1;
`ifdef NORM_DENORM_EN
      wide   = longint'(m) << ((e >= 1) ? (e - 1) : 0);
      r.mant = 24'(wide & 64'hFF_FFFF);
      r.zero = (r.mant == 24'd0);
`else
      r.zero = 1'b1;
`endif
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the scoreboard, then advance the model by this cycle's transfers.
  always @(negedge clk) begin
    beat_t b;
    bit    exp_valid;
    if (!rst_n) begin
      q.delete();
      cnt_model = 0;
    end else begin
      exp_valid = (q.size() > 0) && ((cyc - q[0].t) >= 2);
      check("o_ready", 32'(o_ready), 32'(!(q.size() >= 2 && !i_ready)));
      check("o_valid", 32'(o_valid), 32'(exp_valid));
      check("o_underflow_cnt", 32'(o_underflow_cnt), 32'(cnt_model));
      if (!o_ready) saw_ready_low = 1'b1;
      if (exp_valid && o_valid) begin
        check("o_sign", 32'(o_sign), 32'(q[0].sign));
        check("o_exp", 32'(o_exp), 32'(q[0].exp));
        check("o_mant", 32'(o_mant), 32'(q[0].mant));
        check("o_zero", 32'(o_zero), 32'(q[0].zero));
        check("o_underflow", 32'(o_underflow), 32'(q[0].under));
      end
      if (o_valid && i_ready && q.size() > 0) begin
        if (q[0].under && cnt_model < 65535) cnt_model++;
        void'(q.pop_front());
        n_out++;
      end
      if (i_valid && o_ready) begin
        b   = model(i_sign, int'(i_exp), int'(i_mant), int'(i_one_position), i_zero_flag);
        b.t = cyc;
        q.push_back(b);
      end
    end
  end

  // Entered at posedge+1; returns at posedge+1 of the cycle after the beat was accepted.
  task automatic send_beat(input bit s, input int e, input int m, input int p, input bit zf);
    bit acc;
    int n;
    i_valid        = 1'b1;
    i_sign         = s;
    i_exp          = 8'(e);
    i_mant         = 24'(m);
    i_one_position = 5'(p);
    i_zero_flag    = zf;
    acc = 1'b0;
    n   = 0;
    do begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  // One isolated beat, then hand-computed expectations two cycles after its transfer.
  task automatic send_literal(input string tag, input bit s, input int e, input int m, input int p,
                              input bit zf, input bit x_sign, input int x_exp, input int x_mant,
                              input bit x_zero, input bit x_under);
    send_beat(s, e, m, p, zf);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_sign"}, 32'(o_sign), 32'(x_sign));
    check({tag, "_exp"}, 32'(o_exp), 32'(x_exp));
    check({tag, "_mant"}, 32'(o_mant), 32'(x_mant));
    check({tag, "_zero"}, 32'(o_zero), 32'(x_zero));
    check({tag, "_under"}, 32'(o_underflow), 32'(x_under));
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() > 0) check({tag, "_drain_timeout"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int out_before;
    rst_n          = 1'b0;
    i_valid        = 1'b0;
    i_sign         = 1'b0;
    i_exp          = 8'd0;
    i_mant         = 24'd0;
    i_one_position = 5'd0;
    i_zero_flag    = 1'b0;
    i_ready        = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_ready", 32'(o_ready), 32'd1);
    check("rst_cnt", 32'(o_underflow_cnt), 32'd0);
    check("rst_o_mant", 32'(o_mant), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_literal("normal", 1'b0, 100, 'h000800, 11, 1'b0, 1'b0, 88, 'h800000, 1'b0, 1'b0);
    send_literal("already", 1'b0, 5, 'hC00000, 23, 1'b0, 1'b0, 5, 'hC00000, 1'b0, 1'b0);
    send_literal("zero", 1'b1, 77, 'h000000, 0, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0);
    check("zero_cnt", 32'(o_underflow_cnt), 32'd0);
`ifdef NORM_DENORM_EN
    send_literal("under", 1'b0, 10, 'h000001, 0, 1'b0, 1'b0, 0, 'h000200, 1'b0, 1'b1);
`else
    send_literal("under", 1'b0, 10, 'h000001, 0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
`endif
    check("under_cnt_before", 32'(o_underflow_cnt), 32'd0);
    @(posedge clk);
    #1;
    check("under_cnt_after", 32'(o_underflow_cnt), 32'd1);

    // Boundary vectors streamed back to back: exp == sh, clamped positions, exp 0, max exp.
    send_beat(1'b0, 13, 'h000800, 11, 1'b0);
    send_beat(1'b1, 12, 'h000800, 11, 1'b0);
    send_beat(1'b0, 3, 'h400000, 31, 1'b0);
    send_beat(1'b0, 0, 'h900000, 23, 1'b0);
    send_beat(1'b1, 1, 'h000010, 4, 1'b0);
    send_beat(1'b0, 255, 'h000001, 0, 1'b0);
    send_beat(1'b0, 5, 'h000000, 0, 1'b1);
    send_beat(1'b1, 200, 'hABCDEF, 26, 1'b0);
    i_valid = 1'b0;
    wait_drain("table");

    // Back-pressure: four beats, downstream stalls three cycles after the first output.
    saw_ready_low = 1'b0;
    out_before    = n_out;
    fork
      begin
        send_beat(1'b0, 40, 'h000123, 8, 1'b0);
        send_beat(1'b1, 2, 'h000456, 10, 1'b0);
        send_beat(1'b0, 30, 'h078000, 18, 1'b0);
        send_beat(1'b1, 9, 'h000003, 1, 1'b0);
        i_valid = 1'b0;
      end
      begin
        n = 0;
        while (!o_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        if (!o_valid) check("bp_first_valid_timeout", 32'd0, 32'd1);
        i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    wait_drain("bp");
    check("bp_ready_fell", 32'(saw_ready_low), 32'd1);
    check("bp_beat_count", 32'(n_out - out_before), 32'd4);

    // Reset with both stages full: outputs clear before any clock edge.
    i_ready = 1'b0;
    send_beat(1'b1, 100, 'h000800, 11, 1'b0);
    send_beat(1'b0, 4, 'h000001, 0, 1'b0);
    i_valid = 1'b0;
    check("full_o_valid", 32'(o_valid), 32'd1);
    check("full_o_ready", 32'(o_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_o_valid", 32'(o_valid), 32'd0);
    check("async_cnt", 32'(o_underflow_cnt), 32'd0);
    check("async_o_mant", 32'(o_mant), 32'd0);
    check("async_o_exp", 32'(o_exp), 32'd0);
    check("async_o_ready", 32'(o_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    i_ready = 1'b1;
    send_literal("post_rst", 1'b1, 50, 'h0000F0, 7, 1'b0, 1'b1, 34, 'hF00000, 1'b0, 1'b0);
    wait_drain("post_rst");
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/norm_shift_pipe.md
# norm_shift_pipe

Two-stage pipelined normalization stage for the 24-bit floating-point mantissa datapath. It consumes a mantissa together with the leading-one position and zero flag produced by the 24-bit leading-one position detector, left-shifts the mantissa so bit 23 is the leading one, and adjusts the 8-bit biased exponent. Underflow is handled as denormalization or flush-to-zero. A valid/ready handshake allows back-pressure from the rounding stage downstream.

## Interface
- SIZE_DATA, 24, mantissa width including hidden bit
- SIZE_LOPD, 5, leading-one position width
- SIZE_EXP, 8, biased exponent width
- SIZE_CNT, 16, underflow event counter width

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  stage can accept input this cycle
- i_sign  in  1  sign, passed through
- i_exp  in  SIZE_EXP  biased exponent before normalization
- i_mant  in  SIZE_DATA  unnormalized mantissa
- i_one_position  in  SIZE_LOPD  index of leading one in i_mant (0..23)
- i_zero_flag  in  1  i_mant is all zeros
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts output
- o_sign  out  1  registered sign
- o_exp  out  SIZE_EXP  adjusted exponent
- o_mant  out  SIZE_DATA  normalized mantissa
- o_zero  out  1  result is zero
- o_underflow  out  1  result underflowed the normal range
- o_underflow_cnt  out  SIZE_CNT  saturating count of accepted underflow results

## Operation
- Input transfer: i_valid & o_ready. Output transfer: o_valid & i_ready.
- Stage 1 (S1) registers sign, mantissa, and path decision; stage 2 (S2) applies the shift and registers the outputs.
- Shift: sh = 23 - i_one_position. Positions 24..31 are clamped to 23, giving sh = 0.
- Path selection, computed in S1 with 9-bit unsigned compare:
  - ZERO: i_zero_flag = 1 → o_mant 0, o_exp 0, o_zero 1, o_underflow 0.
  - NORMAL: i_exp > sh → o_mant = i_mant << sh, o_exp = i_exp - sh.
  - UNDER: i_exp ≤ sh and not ZERO → o_underflow 1. Result depends on configuration.
- Sign passes through unchanged on all paths, including ZERO.
- o_underflow_cnt increments by 1 on each output transfer with o_underflow = 1, and holds at all-ones.

## Timing
- Latency: 2 cycles, from input transfer to o_valid, with no stall.
- Throughput: 1 beat/cycle.
- Each stage advances when it is empty or the stage after it is accepting:
  - s2_adv = ~o_valid | i_ready
  - s1_adv = ~s1_valid | s2_adv
  - o_ready = s1_adv (combinational from i_ready; no skid)
- While o_valid = 1 and i_ready = 0, all outputs are held stable.
- Simultaneous input and output transfer in one cycle: both complete; no bubble.
- Reset asserted at any time clears s1_valid, o_valid, all data outputs, and o_underflow_cnt to 0 immediately. In-flight beats are discarded.
- After reset release: o_ready = 1 in the first cycle.

## Configuration
- NORM_DENORM_EN defined: UNDER path produces a denormal result.
  - i_exp ≥ 1 → o_mant = i_mant << (i_exp - 1), o_exp = 0.
  - i_exp = 0 → o_mant = i_mant, o_exp = 0.
  - o_zero = 1 only if the shifted mantissa is 0.
- NORM_DENORM_EN undefined: UNDER path flushes to zero.
  - o_mant = 0, o_exp = 0, o_zero = 1.
- o_underflow and counter behaviour are identical in both builds.

## Test plan
- Normal: i_mant 0x000800, pos 11, i_exp 100 → after 2 cycles o_mant 0x800000, o_exp 88, o_zero 0, o_underflow 0.
- Already normal: i_mant 0xC00000, pos 23, i_exp 5 → o_mant 0xC00000, o_exp 5.
- Zero: i_zero_flag 1, i_exp 77, i_sign 1 → o_mant 0, o_exp 0, o_zero 1, o_sign 1, counter unchanged.
- Underflow: i_mant 0x000001, pos 0, i_exp 10.
  - With NORM_DENORM_EN: o_mant 0x000200, o_exp 0, o_underflow 1.
  - Without: o_mant 0, o_zero 1, o_underflow 1.
  - Both builds: o_underflow_cnt goes 0 → 1.
- Back-pressure: stream 4 beats with i_ready held 0 for 3 cycles after the first o_valid.
  - o_ready falls once both stages are full; outputs stay stable.
  - All 4 beats emerge in order with no loss or duplication.
- Reset mid-stream: assert i_rst_n low with both stages full → o_valid 0 and counter 0 in the same cycle, before any clock edge. First beat after release appears 2 cycles after its input transfer.
